// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// The optional out_illegal port is enabled with IMM_GEN_ILLEGAL_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_SH   = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    // Bit 0 is the output-valid flag, bit 1 the skid-valid flag.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } skid_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I/RV64I immediate decoder: instruction word -> {imm, fmt}.
// With IMM_GEN_ILLEGAL_EN defined it also flags unrecognised opcodes.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    logic [2:0] funct3;
    logic [5:0] shamt;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        imm    = '0;
        fmt    = FMT_NONE;
`ifdef IMM_GEN_ILLEGAL_EN
        illegal = 1'b0;
`endif
        funct3 = inst[14:12];
        shamt  = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

        // Signed size casts replicate inst[31] up to bit XLEN-1.
        unique case (inst[6:0])
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(inst[31:20]));
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt = FMT_SH;
                    imm = XLEN'(shamt);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(inst[31:20]));
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({inst[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            default: begin
`ifdef IMM_GEN_ILLEGAL_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: 1-cycle decode into a 2-entry skid buffer.
// Define IMM_GEN_ILLEGAL_EN to add the registered out_illegal flag.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic             out_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    // Buffer entry; widths follow the module parameters.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
        logic             illegal;
`endif
    } entry_t;

    skid_state_e state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (new_entry.imm),
        .fmt     (new_entry.fmt)
`ifdef IMM_GEN_ILLEGAL_EN
        ,
        .illegal (new_entry.illegal)
`endif
    );
    assign new_entry.tag = in_tag;

    // Both handshake flags are straight flop bits of the state encoding.
    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        out_d   = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_valid && out_ready) begin
                        out_d = new_entry;
                    end else if (in_valid) begin
                        skid_d  = new_entry;
                        state_d = ST_TWO;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_ready) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            // NOTE: payload registers are reset too because their reset value is visible on the ports.
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_imm = out_q.imm;
    assign out_fmt = out_q.fmt;
    assign out_tag = out_q.tag;
`ifdef IMM_GEN_ILLEGAL_EN
    assign out_illegal = out_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;
    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_imm32, out_tag32, out_tag64;
    logic [63:0] out_imm64;
    imm_fmt_e    out_fmt32, out_fmt64;
`ifdef IMM_GEN_ILLEGAL_EN
    logic        ill32, ill64;
`endif

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(ill32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
`ifdef IMM_GEN_ILLEGAL_EN
        , .out_illegal(ill64)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        imm_fmt_e    fmt;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic        ill;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag_name);
        check({tag_name, " out_valid"}, 64'(out_valid32), 64'd0);
        check({tag_name, " in_ready"},  64'(in_ready32),  64'd1);
        check({tag_name, " out_imm"},   64'(out_imm32),   64'd0);
        check({tag_name, " out_fmt"},   64'(out_fmt32),   64'(FMT_NONE));
        check({tag_name, " out_tag"},   64'(out_tag32),   64'd0);
        check({tag_name, " out_imm64"}, out_imm64,        64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        check({tag_name, " illegal"},   64'(ill32),       64'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag);
        in_valid = v;
        in_inst  = inst;
        in_tag   = tag;
    endtask

    initial begin
        vecs[0]  = '{32'hFFC10113, FMT_I,    32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // addi sp,sp,-4
        vecs[1]  = '{32'h800002B7, FMT_U,    32'h80000000, 64'hFFFFFFFF80000000, 1'b0}; // lui
        vecs[2]  = '{32'h03F51513, FMT_SH,   32'd31,       64'd63,               1'b0}; // slli shamt
        vecs[3]  = '{32'hFE000EE3, FMT_B,    32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // beq -4
        vecs[4]  = '{32'h0044C583, FMT_I,    32'd4,        64'd4,                1'b0}; // lbu 4
        vecs[5]  = '{32'hFE512C23, FMT_S,    32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0}; // sw -8
        vecs[6]  = '{32'hFFDFF0EF, FMT_J,    32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // jal -4
        vecs[7]  = '{32'h0080006F, FMT_J,    32'd8,        64'd8,                1'b0}; // jal +8
        vecs[8]  = '{32'h12345097, FMT_U,    32'h12345000, 64'h0000000012345000, 1'b0}; // auipc
        vecs[9]  = '{32'h7FF08067, FMT_I,    32'h000007FF, 64'h00000000000007FF, 1'b0}; // jalr 2047
        vecs[10] = '{32'h4030D093, FMT_SH,   32'd3,        64'd3,                1'b0}; // srai 3
        vecs[11] = '{32'h80016503, FMT_I,    32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0}; // lwu -2048
        vecs[12] = '{32'h00000000, FMT_NONE, 32'd0,        64'd0,                1'b1}; // all zero
        vecs[13] = '{32'h00B50533, FMT_NONE, 32'd0,        64'd0,                1'b1}; // R-type add

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Table-driven decode: one instruction at a time, output always ready.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].inst, 32'h1000 + 32'(i) * 4);
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0);
            check($sformatf("v%0d out_valid", i), 64'(out_valid32), 64'd1);
            check($sformatf("v%0d imm32", i),     64'(out_imm32),   64'(vecs[i].imm32));
            check($sformatf("v%0d fmt32", i),     64'(out_fmt32),   64'(vecs[i].fmt));
            check($sformatf("v%0d tag", i),       64'(out_tag32),   64'(32'h1000 + 32'(i) * 4));
            check($sformatf("v%0d imm64", i),     out_imm64,        vecs[i].imm64);
            check($sformatf("v%0d fmt64", i),     64'(out_fmt64),   64'(vecs[i].fmt));
`ifdef IMM_GEN_ILLEGAL_EN
            check($sformatf("v%0d illegal32", i), 64'(ill32), 64'(vecs[i].ill));
            check($sformatf("v%0d illegal64", i), 64'(ill64), 64'(vecs[i].ill));
`endif
        end
        @(negedge clk);
        check("drain out_valid", 64'(out_valid32), 64'd0);

        // Back-pressure: three back-to-back inputs with the output stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC10113, 32'h100);
        @(negedge clk);
        check("bp1 in_ready", 64'(in_ready32), 64'd1);
        check("bp1 tag",      64'(out_tag32),  64'h100);
        drive(1'b1, 32'h0044C583, 32'h104);
        @(negedge clk);
        check("bp2 in_ready", 64'(in_ready32), 64'd0);
        check("bp2 tag",      64'(out_tag32),  64'h100);
        check("bp2 imm",      64'(out_imm32),  64'hFFFFFFFC);
        drive(1'b1, 32'h7FF08067, 32'h108);
        @(negedge clk);
        check("bp3 in_ready", 64'(in_ready32), 64'd0);
        check("bp3 tag held", 64'(out_tag32),  64'h100);
        check("bp3 imm held", 64'(out_imm32),  64'hFFFFFFFC);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp4 valid",    64'(out_valid32), 64'd1);
        check("bp4 tag",      64'(out_tag32),   64'h104);
        check("bp4 imm",      64'(out_imm32),   64'd4);
        check("bp4 in_ready", 64'(in_ready32),  64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("bp5 tag",      64'(out_tag32),  64'h108);
        check("bp5 imm",      64'(out_imm32),  64'h7FF);
        @(negedge clk);
        check("bp6 drained",  64'(out_valid32), 64'd0);

        // Flush while both entries are full and a new input is offered.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFC10113, 32'h200);
        @(negedge clk);
        drive(1'b1, 32'h0044C583, 32'h204);
        @(negedge clk);
        check("fl pre in_ready", 64'(in_ready32), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h7FF08067, 32'h208);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl out_valid", 64'(out_valid32), 64'd0);
        check("fl in_ready",  64'(in_ready32),  64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("fl stale%0d", c), 64'(out_valid32), 64'd0);
        end

        // Flush from empty discards the simultaneously offered input.
        flush = 1'b1;
        drive(1'b1, 32'hFFC10113, 32'h20C);
        @(negedge clk);
        flush = 1'b0;
        check("fl empty discard", 64'(out_valid32), 64'd0);
        drive(1'b1, 32'h0044C583, 32'h210);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("post flush tag", 64'(out_tag32), 64'h210);
        check("post flush imm", 64'(out_imm32), 64'd4);

        // Reset mid-stream with both entries full.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'hFE000EE3, 32'h300);
        @(negedge clk);
        drive(1'b1, 32'hFFDFF0EF, 32'h304);
        @(negedge clk);
        check("rs pre in_ready", 64'(in_ready32), 64'd0);
        reset = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rs after valid", 64'(out_valid32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. Accepts one fetched instruction word plus a sideband tag (PC) per handshake. Produces the XLEN-wide sign/zero-extended immediate and a format code one cycle later. Supports the full RV32I/RV64I immediate formats and ships with a 2-entry skid buffer so decode back-pressure never drops an instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (any other value is an elaboration error).
TAG_W, 32, width of the sideband tag (PC) carried alongside each instruction.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous kill of all buffered entries (branch mispredict).
in_valid  input  1  upstream instruction valid.
in_ready  output  1  block can accept an instruction this cycle.
in_inst  input  32  instruction word.
in_tag  input  TAG_W  sideband tag (PC).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_imm  output  XLEN  generated immediate.
out_fmt  output  3  format code (imm_fmt_e).
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_tag=0, skid entry invalid.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_imm, out_fmt and out_tag stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid when the output register is free.
- Skid buffer state: EMPTY -> ONE (output register valid) -> TWO (output and skid registers valid).
- in_ready is a registered signal, equal to !(skid valid). It must not combinationally depend on out_ready.
- Ordering:
  - On output transfer with the skid buffer valid, the skid entry moves to the output register.
  - Simultaneous input transfer and output transfer in ONE: the new entry replaces the output entry and the state stays ONE.
  - Strict FIFO order is preserved.
- Decode is by opcode inst[6:0]. imm is computed at input time and stored, not recomputed at the output.
  - LOAD 0000011, OP-IMM 0010011 (non-shift), JALR 1100111: FMT_I. imm = sext(inst[31:20]). Load offsets are signed for every funct3, including LBU/LHU/LWU.
  - OP-IMM shifts (funct3 001/101): FMT_SH. imm = zext(shamt). shamt = inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
  - STORE 0100011: FMT_S. imm = sext({inst[31:25], inst[11:7]}).
  - BRANCH 1100011: FMT_B. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - LUI 0110111, AUIPC 0010111: FMT_U. imm = sext({inst[31:12], 12'b0}); sign extension matters only when XLEN=64.
  - JAL 1101111: FMT_J. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - All other opcodes: FMT_NONE, imm=0.
- Sign extension always replicates inst[31] to bit XLEN-1.
- Flush:
  - Next cycle: out_valid=0, skid entry invalid, in_ready=1.
  - An input presented in the same cycle as flush is discarded.
  - flush has priority over all handshakes.
- reset has priority over flush. Reset mid-transfer discards all entries.

Optional Feature:
IMM_GEN_ILLEGAL_EN.
- When defined: adds output out_illegal (1 bit, registered with the entry, reset 0). It is set when inst[1:0]!=2'b11 or the opcode is unrecognised; such entries report FMT_NONE.
- When undefined: the port is absent and unrecognised opcodes silently produce FMT_NONE with imm=0.

Decomposition:
- Package imm_gen_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e: FMT_NONE=0, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J.
  - localparam opcode constants (OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR).
  - A packed struct for a buffer entry {imm, fmt, tag[, illegal]}.
- One sub-module, imm_decode_comb (combinational, parametrised by XLEN), computes {imm, fmt}. The top holds the skid-buffer registers and control.

Test Plan:
- XLEN=32, in=0xFFC10113 (addi sp,sp,-4), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, out_fmt=FMT_I.
- XLEN=64, in=0x800002B7 (lui) -> out_imm=0xFFFFFFFF80000000, FMT_U. Then in=0x03F51513 (slli a0,a0,63) -> out_imm=63, FMT_SH.
- XLEN=32, in=0xFE000EE3 (beq, offset -4) -> out_imm=0xFFFFFFFC, FMT_B. Then in=0x0044C583 (lbu, offset 4) -> out_imm=4.
- Back-pressure: hold out_ready=0 and send 3 back-to-back valid inputs -> in_ready drops after the 2nd accept, the 3rd is held. Release out_ready -> outputs arrive in order with tags 0x100, 0x104, 0x108 and none lost.
- flush asserted while in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no stale tag ever appears at the output.
- With IMM_GEN_ILLEGAL_EN defined, in=0x00000000 -> out_illegal=1, FMT_NONE, out_imm=0. Reset asserted mid-stream -> all outputs return to their reset values in the following cycle.
